// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four clients and the round-robin arbiter
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;
  modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with registered one-hot/binary grant and bounded-hold preemption
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter4_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] MH = 8'(MAX_HOLD);
  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, win, idx_n;
  logic [7:0] hold, hold_n;
  logic [3:0] mask, gnt_n;
  logic       found, own_req, take, valid_n, pre_n;
  always_comb begin
    mask = state == IDLE ? bus.req : bus.req & ~bus.gnt;
    found = |mask;
    win = ptr;
    for (int k = 4; k >= 1; k--)
      if (mask[ptr + 2'(k)]) win = ptr + 2'(k);
    own_req = state == GRANT && bus.req[bus.gnt_idx];
    take = found && (!own_req || hold == MH);
    state_n = take || own_req ? GRANT : IDLE;
    ptr_n = take ? win : ptr;
    hold_n = take ? 8'd1 : own_req ? (hold == MH ? hold : hold + 8'd1) : 8'd0;
    gnt_n = take ? 4'b0001 << win : own_req ? bus.gnt : 4'b0000;
    idx_n = take ? win : own_req ? bus.gnt_idx : 2'd0;
    valid_n = take || own_req;
    pre_n = take && own_req;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd3;
      hold <= 8'd0;
      bus.gnt <= 4'b0000;
      bus.gnt_idx <= 2'd0;
      bus.gnt_valid <= 1'b0;
      bus.preempt <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold <= hold_n;
      bus.gnt <= gnt_n;
      bus.gnt_idx <= idx_n;
      bus.gnt_valid <= valid_n;
      bus.preempt <= pre_n;
    end
  end
endmodule
